// File: rtl/mq_transceiver_pkg.sv
// Shared types and constants for the multi-queue transceiver: FSM encoding,
// flit field offsets and counter width.
package mq_transceiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_SEND,
    ST_ACCEPT
  } state_e;

  localparam int DEST_LSB = 0;
  localparam int CNT_W    = 16;

  // The tail flag sits directly above the destination field.
  function automatic int tail_bit(input int addr_size);
    return addr_size;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mq_transceiver_rr_arbiter.sv
// Round-robin queue picker: first requesting queue strictly after last_i,
// in cyclic order. Purely combinational.
module rr_arbiter import mq_transceiver_pkg::*; #(
  parameter int QUEUES_NUM = 2,
  localparam int QW        = idx_w(QUEUES_NUM)
) (
  input  logic [QUEUES_NUM-1:0] req_i,
  input  logic [QW-1:0]         last_i,
  output logic [QUEUES_NUM-1:0] gnt_oh_o,
  output logic [QW-1:0]         gnt_idx_o,
  output logic                  valid_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= QUEUES_NUM; i++) begin
      idx = (int'(last_i) + i) % QUEUES_NUM;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = QW'(idx);
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/routing_module.sv
// XY router on a square mesh: resolves a destination address to an output
// port index; PORTS_NUM means deliver locally.
module routing_module #(
  parameter int ADDR      = 0,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4,
  parameter int NODES_NUM = 9,
  localparam int PW       = $clog2(PORTS_NUM + 1)
) (
  input  logic [ADDR_SIZE-1:0] dest_i,
  output logic [PW-1:0]        port_o
);

  function automatic int mesh_side(input int n);
    int w;
    w = 1;
    while (w * w < n) w++;
    return w;
  endfunction

  localparam int SIDE = mesh_side(NODES_NUM);
  localparam int MY_X = ADDR % SIDE;
  localparam int MY_Y = ADDR / SIDE;

  int dx, dy;

  // Port map: 0 = x-, 1 = x+, 2 = y+, 3 = y-; X is resolved before Y.
  always_comb begin
    dx     = int'(dest_i) % SIDE;
    dy     = int'(dest_i) / SIDE;
    port_o = PW'(PORTS_NUM);
    if (dx > MY_X)      port_o = PW'(1);
    else if (dx < MY_X) port_o = PW'(0);
    else if (dy > MY_Y) port_o = PW'(2);
    else if (dy < MY_Y) port_o = PW'(3);
  end

endmodule

// File: rtl/mq_transceiver.sv
// Multi-queue wormhole transceiver: round-robin over input queues at packet
// granularity, routes on the head flit, forwards flits with valid/ready.
module mq_transceiver import mq_transceiver_pkg::*; #(
  parameter int ADDR       = 0,
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 4,
  parameter int PORTS_NUM  = 4,
  parameter int NODES_NUM  = 9,
  parameter int QUEUES_NUM = 2,
  localparam int BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1,
  localparam int PW        = $clog2(PORTS_NUM + 1),
  localparam int QW        = idx_w(QUEUES_NUM)
) (
  input  logic                                 clk,
  input  logic                                 a_rst_n,
  input  logic [QUEUES_NUM-1:0]                mem_empty,
  input  logic [BUS_SIZE*QUEUES_NUM-1:0]       data_i,
  input  logic [PORTS_NUM:0]                   port_connected,
  input  logic [PORTS_NUM:0]                   r_ready_in,
  output logic [QUEUES_NUM-1:0]                mem_readed,
  output logic [PORTS_NUM:0]                   wr_ready_out,
  output logic [BUS_SIZE*(PORTS_NUM+1)-1:0]    data_o,
  output logic [CNT_W-1:0]                     pkt_cnt
);

  localparam int            TAIL_BIT   = tail_bit(ADDR_SIZE);
  localparam logic [PW-1:0] LOCAL_PORT = PW'(PORTS_NUM);
  localparam logic [QW-1:0] LAST_Q_RST = QW'(QUEUES_NUM - 1);

  state_e                             state_q, state_d;
  logic [QW-1:0]                      grant_q, grant_d;
  logic [QUEUES_NUM-1:0]              grant_oh_q, grant_oh_d;
  logic [QW-1:0]                      last_grant_q, last_grant_d;
  logic [PW-1:0]                      port_r_q, port_r_d;
  logic                               tail_q, tail_d;
  logic [QUEUES_NUM-1:0]              mem_readed_q, mem_readed_d;
  logic [PORTS_NUM:0]                 wr_ready_q, wr_ready_d;
  logic [BUS_SIZE*(PORTS_NUM+1)-1:0]  data_o_q, data_o_d;
  logic [CNT_W-1:0]                   pkt_cnt_q, pkt_cnt_d;

  logic [QW-1:0]                      arb_idx;
  logic [QUEUES_NUM-1:0]              arb_oh;
  logic                               arb_vld;
  logic [PW-1:0]                      route_port;
  logic [PW-1:0]                      send_port;
  logic [BUS_SIZE-1:0]                head;

  assign head = data_i[int'(grant_q)*BUS_SIZE +: BUS_SIZE];

  rr_arbiter #(
    .QUEUES_NUM (QUEUES_NUM)
  ) u_arb (
    .req_i     (~mem_empty),
    .last_i    (last_grant_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .valid_o   (arb_vld)
  );

  routing_module #(
    .ADDR      (ADDR),
    .ADDR_SIZE (ADDR_SIZE),
    .PORTS_NUM (PORTS_NUM),
    .NODES_NUM (NODES_NUM)
  ) u_route (
    .dest_i (head[DEST_LSB +: ADDR_SIZE]),
    .port_o (route_port)
  );

  // A link that drops mid-packet diverts the rest of the packet to local.
  assign send_port = port_connected[port_r_q] ? port_r_q : LOCAL_PORT;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    port_r_d     = port_r_q;
    tail_d       = tail_q;
    mem_readed_d = '0;
    wr_ready_d   = wr_ready_q;
    data_o_d     = data_o_q;
    pkt_cnt_d    = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          state_d    = ST_ROUTE;
        end
      end
      ST_ROUTE: begin
        port_r_d = port_connected[route_port] ? route_port : LOCAL_PORT;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (!mem_empty[grant_q]) begin
          port_r_d                                       = send_port;
          data_o_d[int'(send_port)*BUS_SIZE +: BUS_SIZE] = head;
          wr_ready_d                                     = '0;
          wr_ready_d[send_port]                          = 1'b1;
          mem_readed_d                                   = grant_oh_q;
          tail_d                                         = head[TAIL_BIT];
          state_d                                        = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        // A disconnected receiver can never answer, so its flit is dropped as accepted.
        if (r_ready_in[port_r_q] || !port_connected[port_r_q]) begin
          wr_ready_d = '0;
          if (!port_connected[port_r_q]) port_r_d = LOCAL_PORT;
          if (tail_q) begin
            last_grant_d = grant_q;
            pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= LAST_Q_RST;
      port_r_q     <= LOCAL_PORT;
      tail_q       <= 1'b0;
      mem_readed_q <= '0;
      wr_ready_q   <= '0;
      data_o_q     <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      port_r_q     <= port_r_d;
      tail_q       <= tail_d;
      mem_readed_q <= mem_readed_d;
      wr_ready_q   <= wr_ready_d;
      data_o_q     <= data_o_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign mem_readed   = mem_readed_q;
  assign wr_ready_out = wr_ready_q;
  assign data_o       = data_o_q;
  assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_mq_transceiver.sv
// Bench for mq_transceiver: queue-backed stimulus, transaction-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_mq_transceiver;

  localparam int ADDR      = 0;
  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 4;
  localparam int PORTS_NUM = 4;
  localparam int NODES_NUM = 9;
  localparam int QN        = 2;
  localparam int BUS       = DATA_SIZE + ADDR_SIZE + 1;
  localparam int NP        = PORTS_NUM + 1;
  localparam int LP        = PORTS_NUM;

  logic                clk = 1'b0;
  logic                a_rst_n;
  logic [QN-1:0]       mem_empty;
  logic [BUS*QN-1:0]   data_i;
  logic [NP-1:0]       port_connected;
  logic [NP-1:0]       r_ready_in;
  logic [QN-1:0]       mem_readed;
  logic [NP-1:0]       wr_ready_out;
  logic [BUS*NP-1:0]   data_o;
  logic [15:0]         pkt_cnt;

  mq_transceiver #(
    .ADDR       (ADDR),
    .DATA_SIZE  (DATA_SIZE),
    .ADDR_SIZE  (ADDR_SIZE),
    .PORTS_NUM  (PORTS_NUM),
    .NODES_NUM  (NODES_NUM),
    .QUEUES_NUM (QN)
  ) dut (
    .clk            (clk),
    .a_rst_n        (a_rst_n),
    .mem_empty      (mem_empty),
    .data_i         (data_i),
    .port_connected (port_connected),
    .r_ready_in     (r_ready_in),
    .mem_readed     (mem_readed),
    .wr_ready_out   (wr_ready_out),
    .data_o         (data_o),
    .pkt_cnt        (pkt_cnt)
  );

  always #5 clk = ~clk;

  logic [BUS-1:0] mq [QN][$];
  bit   [QN-1:0]  hold;
  bit   [NP-1:0]  conn_v;
  int             rdy_mode;
  int             n_chk = 0;
  int             n_fail = 0;
  int             pkts_loaded;

  int             ph, eq, lq, pport, cnt;
  bit             ptail, pend;
  logic [BUS-1:0] exp_dat [NP];

  int             obs_rd [QN];
  int             obs_port [NP];
  int             obs_seq [$];
  int             tot_offers;
  logic [NP-1:0]  prev_wr;
  int             exp_seq [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 3x3 mesh, column = addr%3, row = addr/3; X settled before Y.
  function automatic int route(input logic [BUS-1:0] f);
    int d, dc, dr;
    d  = int'(f[ADDR_SIZE-1:0]);
    dc = d % 3;
    dr = d / 3;
    if (dc > ADDR % 3) return 1;
    if (dc < ADDR % 3) return 0;
    if (dr > ADDR / 3) return 2;
    if (dr < ADDR / 3) return 3;
    return LP;
  endfunction

  function automatic int rr_pick(input int last, input logic [QN-1:0] empt);
    for (int k = 1; k <= QN; k++) begin
      if (!empt[(last + k) % QN]) return (last + k) % QN;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int q = 0; q < QN; q++) begin
      mem_empty[q]          = hold[q] || (mq[q].size() == 0);
      data_i[q*BUS +: BUS]  = (mq[q].size() != 0) ? mq[q][0] : '0;
    end
    port_connected     = conn_v;
    port_connected[LP] = 1'b1;
    case (rdy_mode)
      0:       r_ready_in = '1;
      1:       r_ready_in = NP'($urandom);
      default: r_ready_in = '0;
    endcase
  endtask

  task automatic model_reset();
    ph = 0; lq = QN - 1; pend = 0; cnt = 0; pport = LP; ptail = 0; eq = 0;
    for (int p = 0; p < NP; p++) exp_dat[p] = '0;
  endtask

  task automatic clr_obs();
    for (int q = 0; q < QN; q++) obs_rd[q] = 0;
    for (int p = 0; p < NP; p++) obs_port[p] = 0;
    obs_seq.delete();
    tot_offers = 0;
  endtask

  task automatic load_pkt(input int q, input int dest, input int len);
    logic [BUS-1:0] f;
    for (int i = 0; i < len; i++) begin
      f                      = '0;
      f[ADDR_SIZE-1:0]       = ADDR_SIZE'(dest);
      f[ADDR_SIZE]           = (i == len - 1);
      f[BUS-1:ADDR_SIZE+1]   = DATA_SIZE'($urandom);
      mq[q].push_back(f);
    end
    pkts_loaded++;
  endtask

  // One clock: advance the packet-level model over the edge, compare, drive.
  task automatic step();
    logic [BUS*NP-1:0] exp_bus;
    logic [QN-1:0]     exp_rd;
    logic [NP-1:0]     exp_wr;
    bit                offer;
    int                r;
    @(negedge clk);
    offer = 0;
    case (ph)
      0: if (mem_empty != '1) begin eq = rr_pick(lq, mem_empty); ph = 1; end
      1: begin
        r     = route(mq[eq][0]);
        pport = port_connected[r] ? r : LP;
        ph    = 2;
      end
      2: if (!mem_empty[eq]) begin
        if (!port_connected[pport]) pport = LP;
        offer          = 1;
        exp_dat[pport] = mq[eq][0];
        ptail          = mq[eq][0][ADDR_SIZE];
        pend           = 1;
        ph             = 3;
      end
      default: if (r_ready_in[pport] || !port_connected[pport]) begin
        if (!port_connected[pport]) pport = LP;
        pend = 0;
        if (ptail) begin cnt = (cnt + 1) % 65536; lq = eq; ph = 0; end
        else ph = 2;
      end
    endcase
    exp_rd = '0;
    if (offer) exp_rd[eq] = 1'b1;
    exp_wr = '0;
    if (pend) exp_wr[pport] = 1'b1;
    for (int p = 0; p < NP; p++) exp_bus[p*BUS +: BUS] = exp_dat[p];
    chk("mem_readed", mem_readed, exp_rd);
    chk("wr_ready_out", wr_ready_out, exp_wr);
    chk("data_o", data_o, exp_bus);
    chk("pkt_cnt", pkt_cnt, cnt[15:0]);
    chk("wr_ready_onehot", $countones(wr_ready_out) <= 1, 1);
    for (int q = 0; q < QN; q++)
      if (mem_readed[q]) begin obs_rd[q]++; obs_seq.push_back(q); tot_offers++; end
    for (int p = 0; p < NP; p++)
      if (wr_ready_out[p] && !prev_wr[p]) obs_port[p]++;
    prev_wr = wr_ready_out;
    if (offer) void'(mq[eq].pop_front());
    drive();
  endtask

  task automatic wait_offers(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (tot_offers < n && k < budget) begin step(); k++; end
    chk(name, tot_offers >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int  k;
    bit  busy;
    k = 0;
    busy = 1;
    while (busy && k < budget) begin
      step();
      k++;
      busy = (ph != 0);
      for (int q = 0; q < QN; q++) if (mq[q].size() != 0) busy = 1;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    logic [BUS-1:0] last_f;
    int             lat;
    a_rst_n = 1'b0; conn_v = '1; hold = '0; rdy_mode = 0; pkts_loaded = 0;
    model_reset(); clr_obs(); prev_wr = '0;
    drive();
    @(negedge clk);
    chk("reset_mem_readed", mem_readed, 0);
    chk("reset_wr_ready", wr_ready_out, 0);
    chk("reset_data_o", data_o, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    a_rst_n = 1'b1;

    // two queues, two 2-flit packets each: packet-granular alternation from q0
    load_pkt(0, 1, 2); load_pkt(0, 1, 2);
    load_pkt(1, 3, 2); load_pkt(1, 3, 2);
    drive();
    wait_idle(300, "rr_drain");
    chk("rr_seq_len", obs_seq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("rr_seq", (i < obs_seq.size()) ? obs_seq[i] : -1, exp_seq[i]);
    chk("rr_pkt_cnt", pkt_cnt, 4);

    // single 3-flit packet to port 1, with head latency
    clr_obs();
    load_pkt(0, 1, 3);
    last_f = mq[0][2];
    drive();
    lat = 0;
    while (!wr_ready_out[1] && lat < 10) begin step(); lat++; end
    chk("head_latency", lat, 3);
    wait_idle(200, "single_drain");
    chk("single_port1_pulses", obs_port[1], 3);
    chk("single_pops_q0", obs_rd[0], 3);
    chk("single_pkt_cnt", pkt_cnt, 5);
    chk("single_last_flit", data_o[1*BUS +: BUS], last_f);

    // head routed to a disconnected port 2 goes local
    clr_obs();
    conn_v[2] = 1'b0;
    load_pkt(1, 3, 2);
    drive();
    wait_idle(200, "unconn_drain");
    chk("unconn_local_pulses", obs_port[LP], 2);
    chk("unconn_port2_pulses", obs_port[2], 0);
    conn_v = '1;

    // port 1 drops after the first of four flits
    clr_obs();
    load_pkt(0, 1, 4);
    drive();
    wait_offers(1, 50, "disc_first_flit");
    conn_v[1] = 1'b0;
    drive();
    wait_idle(200, "disc_drain");
    chk("disc_port1_pulses", obs_port[1], 1);
    chk("disc_local_pulses", obs_port[LP], 3);
    conn_v = '1;

    // receiver stall, then the active queue runs dry mid-packet
    clr_obs();
    rdy_mode = 2;
    load_pkt(1, 2, 3);
    drive();
    wait_offers(1, 50, "stall_first_flit");
    repeat (20) step();
    chk("stall_no_extra_pop", obs_rd[1], 1);
    load_pkt(0, 1, 2);
    rdy_mode = 0;
    drive();
    wait_offers(2, 50, "lock_second_flit");
    hold[1] = 1'b1;
    drive();
    repeat (5) step();
    chk("lock_other_not_granted", obs_rd[0], 0);
    hold = '0;
    drive();
    wait_idle(200, "lock_drain");
    chk("lock_pops_q0", obs_rd[0], 2);
    chk("lock_pops_q1", obs_rd[1], 3);

    // asynchronous reset while a flit waits for acceptance
    clr_obs();
    rdy_mode = 2;
    load_pkt(0, 1, 4);
    drive();
    wait_offers(1, 50, "rst_first_flit");
    a_rst_n = 1'b0;
    #1;
    chk("rst_async_mem_readed", mem_readed, 0);
    chk("rst_async_wr_ready", wr_ready_out, 0);
    chk("rst_async_data_o", data_o, 0);
    chk("rst_async_pkt_cnt", pkt_cnt, 0);
    model_reset();
    for (int q = 0; q < QN; q++) mq[q].delete();
    hold = '0; pkts_loaded = 0;
    load_pkt(1, 4, 2); load_pkt(0, 3, 2);
    rdy_mode = 0;
    drive();
    clr_obs(); prev_wr = '0;
    #1 a_rst_n = 1'b1;
    wait_offers(1, 50, "post_rst_first");
    chk("post_rst_q0_first", (obs_seq.size() != 0) ? obs_seq[0] : -1, 0);
    wait_idle(200, "post_rst_drain");
    chk("post_rst_pkt_cnt", pkt_cnt, 2);

    // randomized traffic, backpressure and link flaps
    rdy_mode = 1;
    for (int c = 0; c < 800; c++) begin
      int q;
      q = $urandom_range(0, QN - 1);
      if ($urandom_range(0, 7) == 0 && mq[q].size() < 12)
        load_pkt(q, $urandom_range(0, NODES_NUM - 1), $urandom_range(1, 4));
      if ($urandom_range(0, 29) == 0) conn_v[$urandom_range(0, 3)] ^= 1'b1;
      drive();
      step();
    end
    conn_v = '1; rdy_mode = 0;
    drive();
    wait_idle(3000, "random_drain");
    chk("random_pkt_total", pkt_cnt, pkts_loaded);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mq_transceiver.md
# mq_transceiver

Multi-queue output transceiver for the PGNoC switch: drains flits from QUEUES_NUM local input queues and forwards whole packets (wormhole) to one of PORTS_NUM neighbour ports or the local port, using per-port valid/ready handshakes. Queues are served round-robin at packet granularity. Each packet is routed once, on its head flit, by the existing routing_module. Ports are connected through an explicit connection mask rather than high-Z sensing. The block sits between the switch input queues and the link output buses, and generalises the single-queue transceiver.

## Interface
- ADDR, 0, this switch's node address
- DATA_SIZE, 32, flit payload bits
- ADDR_SIZE, 4, destination address bits
- PORTS_NUM, 4, neighbour ports; index PORTS_NUM is the local/loopback port
- NODES_NUM, 9, nodes in the network; passed to routing_module
- QUEUES_NUM, 2, input queues, >=1
- BUS_SIZE (localparam), DATA_SIZE+ADDR_SIZE+1; flit layout: [ADDR_SIZE-1:0] destination, [ADDR_SIZE] tail flag, upper bits payload
- clk  in  1  clock; all state on posedge
- a_rst_n  in  1  reset; asynchronous, active-low
- mem_empty  in  QUEUES_NUM  per-queue empty flag
- data_i  in  BUS_SIZE*QUEUES_NUM  head flit of each queue; queue q occupies slice q
- port_connected  in  PORTS_NUM+1  1 = port has a live link; bit PORTS_NUM tied 1
- r_ready_in  in  PORTS_NUM+1  receiver accepted the flit on that port
- mem_readed  out  QUEUES_NUM  one-cycle pop pulse to queue q
- wr_ready_out  out  PORTS_NUM+1  flit valid on that port
- data_o  out  BUS_SIZE*(PORTS_NUM+1)  per-port flit bus
- pkt_cnt  out  16  packets completed since reset

## Operation
- States: IDLE, ROUTE, SEND, ACCEPT.
- IDLE: if any mem_empty bit is low, grant = first non-empty queue after last_grant (cyclic order) -> ROUTE. Otherwise stay.
- ROUTE: route data_i[grant] destination.
  - port_r = port_connected[port] ? port : PORTS_NUM.
  - -> SEND.
- SEND: if !mem_empty[grant]:
  - data_o slice port_r <= data_i[grant]; wr_ready_out[port_r] <= 1; mem_readed[grant] <= 1 for one cycle.
  - tail_r <= flit bit ADDR_SIZE.
  - -> ACCEPT.
  - If the queue is empty, wait in SEND. The lock is held and other queues are not served.
- ACCEPT: on r_ready_in[port_r]==1, wr_ready_out[port_r] <= 0. Then:
  - If tail_r: last_grant <= grant; pkt_cnt++ (wraps at 2^16); -> IDLE.
  - Else -> SEND.
- Mid-packet disconnect: port_connected[port_r] falls while in ACCEPT or SEND.
  - The pending flit counts as accepted.
  - Remaining flits of the packet go to port PORTS_NUM.
- Destination == ADDR: routing_module yields PORTS_NUM (local delivery).
- Only one wr_ready_out bit is high at any time. Unused data_o slices hold their last value.
- Tail decision uses the latched tail_r, never the data_o bus.

## Timing
- Reset (async, a_rst_n low) sets:
  - state IDLE; grant 0; last_grant QUEUES_NUM-1, so queue 0 has first priority;
  - port_r PORTS_NUM; tail_r 0;
  - mem_readed 0; wr_ready_out 0; data_o 0; pkt_cnt 0.
- Reset asserted mid-packet: outputs drop immediately. The partial packet is abandoned and the receiver handles it.
- Head-flit latency: mem_empty low in the IDLE cycle -> wr_ready_out high 3 edges later.
- Throughput: 2 cycles per flit when r_ready_in is already high. Unbounded stall while r_ready_in stays low.
- mem_readed pulses on the same edge that raises wr_ready_out. data_i must present the next flit by the following SEND cycle.
- Simultaneous requests: the round-robin pointer advances only at tail completion. A single active queue is re-granted back-to-back.

## Structure
- Package mq_transceiver_pkg holds:
  - the state encoding;
  - flit field offsets (DEST_LSB=0, TAIL_BIT=ADDR_SIZE);
  - the counter width.
- Sub-module rr_arbiter: QUEUES_NUM request vector plus last_grant in, one-hot/index grant out; purely combinational.
- One routing_module instance on the muxed head flit.

## Test plan
- Single queue, 3-flit packet to a connected port 1 (dest routes to 1) -> three wr_ready_out[1] pulses, data_o slice 1 matches each flit, mem_readed[0] pulses 3 times, pkt_cnt=1.
- Queues 0 and 1 each hold two 2-flit packets, ready always high -> packet order q0,q1,q0,q1 with no interleaved flits; pkt_cnt=4.
- Head routes to port 2 with port_connected[2]=0 -> whole packet appears on port PORTS_NUM.
- Disconnect port 1 after flit 1 of 4 -> flits 2-4 go to port PORTS_NUM; no deadlock.
- r_ready_in held low 20 cycles -> wr_ready_out and data_o stable, no extra mem_readed. Queue empties mid-packet for 5 cycles -> the other queue is not granted.
- a_rst_n pulled low during ACCEPT -> all outputs 0 the same cycle. After release, queue 0 is granted first.
